// File: rtl/pg_port_rst_quiesce.sv
// Per-port reset sequencer: synchronises per-port reset requests, drains in-flight
// TX packets before asserting port reset. Optional event counters: PG_RST_SEQ_STATS_EN.
module pg_port_rst_quiesce #(
  parameter int NUM_PORTS      = 4,
  parameter int RST_PIPE_DEPTH = 4,
  parameter int RELEASE_HOLD   = 16,
  parameter int DRAIN_TIMEOUT  = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] port_rst_req_n,
  input  logic [NUM_PORTS-1:0] tx_tvalid,
  input  logic [NUM_PORTS-1:0] tx_tready,
  input  logic [NUM_PORTS-1:0] tx_tlast,
  output logic [NUM_PORTS-1:0] tx_block,
  output logic [NUM_PORTS-1:0] port_rst_n_out,
  output logic [NUM_PORTS-1:0] port_quiesced,
  output logic [NUM_PORTS-1:0] drain_timeout_err
`ifdef PG_RST_SEQ_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0] rst_event_cnt
`endif
);

  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int HCW = $clog2(RELEASE_HOLD + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RESET   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic rst_n_out;
    logic block;
    logic quiesced;
  } port_out_t;

  function automatic port_out_t decode(state_e s);
    port_out_t o;
    o.rst_n_out = (s != ST_RESET);
    o.block     = (s != ST_RUN);
    o.quiesced  = (s == ST_RESET);
    return o;
  endfunction

  // Request synchroniser; a registered rst_n keeps requests asserted for one
  // cycle after global reset lifts so every port starts from RESET.
  logic                 rst_q;
  logic [NUM_PORTS-1:0] sync_q [RST_PIPE_DEPTH];
  logic [NUM_PORTS-1:0] req_q;

  // NOTE: every sync stage is reset so requests read as asserted while rst_n is low;
  // this is a flop pipeline, not a RAM, so resetting the array costs nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q <= 1'b0;
      for (int s = 0; s < RST_PIPE_DEPTH; s++) sync_q[s] <= '0;
    end else begin
      rst_q     <= 1'b1;
      sync_q[0] <= port_rst_req_n & {NUM_PORTS{rst_q}};
      for (int s = 1; s < RST_PIPE_DEPTH; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req_q = sync_q[RST_PIPE_DEPTH-1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_e         state_q;
    port_out_t      out_q;
    logic [DCW-1:0] drain_cnt_q;
    logic [HCW-1:0] hold_cnt_q;
    logic           in_pkt_q;
    logic           in_pkt_d;
    logic           err_q;
    logic           beat;
    logic           drain_exit;

    assign beat = tx_tvalid[p] & tx_tready[p];

    // in_pkt_d already reflects this cycle's beat, so a tlast on the DRAIN
    // entry cycle or on the timeout cycle wins over the timeout.
    always_comb begin
      in_pkt_d = in_pkt_q;
      if (beat) in_pkt_d = ~tx_tlast[p];
      drain_exit = ~in_pkt_d | (drain_cnt_q == DCW'(DRAIN_TIMEOUT));
    end

    // NOTE: all state here uses non-blocking assignments; later assignments in the
    // same pass override earlier ones (e.g. in_pkt forced low in RESET).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= ST_RESET;
        out_q       <= decode(ST_RESET);
        drain_cnt_q <= '0;
        hold_cnt_q  <= '0;
        in_pkt_q    <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        in_pkt_q <= in_pkt_d;
        case (state_q)
          ST_RUN: begin
            if (!req_q[p]) begin
              state_q     <= ST_DRAIN;
              out_q       <= decode(ST_DRAIN);
              drain_cnt_q <= '0;
            end
          end
          ST_DRAIN: begin
            if (drain_exit) begin
              state_q    <= ST_RESET;
              out_q      <= decode(ST_RESET);
              hold_cnt_q <= '0;
              in_pkt_q   <= 1'b0;
              if (in_pkt_d) err_q <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
          ST_RESET: begin
            in_pkt_q <= 1'b0;
            if (hold_cnt_q == HCW'(RELEASE_HOLD)) begin
              if (req_q[p]) begin
                state_q <= ST_RELEASE;
                out_q   <= decode(ST_RELEASE);
              end
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: begin
            if (!req_q[p]) begin
              state_q    <= ST_RESET;
              out_q      <= decode(ST_RESET);
              hold_cnt_q <= '0;
            end else begin
              state_q <= ST_RUN;
              out_q   <= decode(ST_RUN);
            end
          end
        endcase
      end
    end

    assign port_rst_n_out[p]    = out_q.rst_n_out;
    assign tx_block[p]          = out_q.block;
    assign port_quiesced[p]     = out_q.quiesced;
    assign drain_timeout_err[p] = err_q;

`ifdef PG_RST_SEQ_STATS_EN
    logic [15:0] evt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        evt_cnt_q <= '0;
      end else if (state_q == ST_DRAIN && drain_exit && evt_cnt_q != 16'hFFFF) begin
        evt_cnt_q <= evt_cnt_q + 16'd1;
      end
    end

    assign rst_event_cnt[p*16 +: 16] = evt_cnt_q;
`endif
  end

endmodule

// File: tb/tb_pg_port_rst_quiesce.sv
// Self-checking bench for pg_port_rst_quiesce: expectations queued as stimulus
// is applied, popped and compared when the DUT response is sampled.
module tb_pg_port_rst_quiesce;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] port_rst_req_n;
  logic [NP-1:0] tx_tvalid;
  logic [NP-1:0] tx_tready;
  logic [NP-1:0] tx_tlast;
  logic [NP-1:0] tx_block;
  logic [NP-1:0] port_rst_n_out;
  logic [NP-1:0] port_quiesced;
  logic [NP-1:0] drain_timeout_err;
`ifdef PG_RST_SEQ_STATS_EN
  logic [NP*16-1:0] rst_event_cnt;
`endif

  pg_port_rst_quiesce #(
    .NUM_PORTS     (NP),
    .RST_PIPE_DEPTH(4),
    .RELEASE_HOLD  (16),
    .DRAIN_TIMEOUT (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .port_rst_req_n   (port_rst_req_n),
    .tx_tvalid        (tx_tvalid),
    .tx_tready        (tx_tready),
    .tx_tlast         (tx_tlast),
    .tx_block         (tx_block),
    .port_rst_n_out   (port_rst_n_out),
    .port_quiesced    (port_quiesced),
    .drain_timeout_err(drain_timeout_err)
`ifdef PG_RST_SEQ_STATS_EN
    ,
    .rst_event_cnt    (rst_event_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    e = sb_q.pop_front();
    check(e.tag, obs, e.exp);
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_pop(obs);
  endtask

  // One clock: active edge, then settle at the falling edge where inputs change
  // and outputs are sampled.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic sig(input int which, input int p);
    case (which)
      0:       return tx_block[p];
      1:       return port_rst_n_out[p];
      default: return port_quiesced[p];
    endcase
  endfunction

  // Bounded wait; returns the cycles spent. Caller compares the signal afterwards.
  task automatic wait_sig(input int which, input int p, input logic val, output int cyc);
    cyc = 0;
    while (sig(which, p) !== val && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_port(input int p, input string tag);
    int cyc;
    port_rst_req_n[p] = 1'b1;
    wait_sig(1, p, 1'b1, cyc);
    expect_now({tag, "_rel"}, 32'(port_rst_n_out[p]), 32'd1);
    tick();
    expect_now({tag, "_run"}, 32'(tx_block[p]), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_req;
    rst_n          = 1'b0;
    port_rst_req_n = '1;
    tx_tvalid      = '0;
    tx_tready      = '1;
    tx_tlast       = '0;

    // Power-on
    sb_push("rst_rstn", 32'h0);
    sb_push("rst_block", 32'hF);
    sb_push("rst_quiesced", 32'hF);
    sb_push("rst_err", 32'h0);
    tick(5);
    sb_pop(32'(port_rst_n_out));
    sb_pop(32'(tx_block));
    sb_pop(32'(port_quiesced));
    sb_pop(32'(drain_timeout_err));
    rst_n = 1'b1;
    cyc = 0;
    while (port_rst_n_out !== 4'hF && cyc < 60) begin
      tick();
      cyc++;
    end
    expect_now("po_release", 32'(port_rst_n_out), 32'hF);
    expect_now("po_min_hold", 32'(cyc >= 16), 32'd1);
    expect_now("po_block_rel", 32'(tx_block), 32'hF);
    tick();
    expect_now("po_block_run", 32'(tx_block), 32'h0);
    expect_now("po_quiesced", 32'(port_quiesced), 32'h0);

    // Idle reset on port 1: falls on the sixth edge counting the sampling edge
    port_rst_req_n[1] = 1'b0;
    sb_push("idle_pre", 32'hF);
    sb_push("idle_fall", 32'hD);
    sb_push("idle_block", 32'h2);
    sb_push("idle_quiesced", 32'h2);
    tick(5);
    sb_pop(32'(port_rst_n_out));
    tick();
    sb_pop(32'(port_rst_n_out));
    sb_pop(32'(tx_block));
    sb_pop(32'(port_quiesced));
    release_port(1, "idle");

    // Drain on port 2: packet open, three beats left once DRAIN is entered
    tx_tvalid[2] = 1'b1;
    tick();
    tx_tvalid[2] = 1'b0;
    port_rst_req_n[2] = 1'b0;
    wait_sig(0, 2, 1'b1, cyc);
    expect_now("drain_block", 32'(tx_block[2]), 32'd1);
    expect_now("drain_alive", 32'(port_rst_n_out[2]), 32'd1);
    for (int b = 0; b < 3; b++) begin
      tx_tvalid[2] = 1'b1;
      tx_tlast[2]  = (b == 2);
      sb_push($sformatf("drain_beat%0d", b), (b == 2) ? 32'd0 : 32'd1);
      tick();
      sb_pop(32'(port_rst_n_out[2]));
    end
    tx_tvalid[2] = 1'b0;
    tx_tlast[2]  = 1'b0;
    expect_now("drain_err", 32'(drain_timeout_err), 32'h0);
    release_port(2, "drain");

    // Timeout on port 0: stalled packet, reset forced after 9 DRAIN cycles
    tx_tvalid[0] = 1'b1;
    tick();
    tx_tready[0] = 1'b0;
    port_rst_req_n[0] = 1'b0;
    wait_sig(0, 0, 1'b1, cyc);
    tick(8);
    expect_now("to_pre", 32'(port_rst_n_out[0]), 32'd1);
    tick();
    expect_now("to_fall", 32'(port_rst_n_out[0]), 32'd0);
    expect_now("to_err", 32'(drain_timeout_err), 32'h1);
    tx_tvalid[0] = 1'b0;
    tx_tready[0] = 1'b1;
    release_port(0, "to");
    expect_now("to_sticky", 32'(drain_timeout_err), 32'h1);

    // Timeout and tlast in the same cycle on port 3: tlast wins, no error
    tx_tvalid[3] = 1'b1;
    tick();
    tx_tvalid[3] = 1'b0;
    port_rst_req_n[3] = 1'b0;
    wait_sig(0, 3, 1'b1, cyc);
    tick(8);
    tx_tvalid[3] = 1'b1;
    tx_tlast[3]  = 1'b1;
    tick();
    tx_tvalid[3] = 1'b0;
    tx_tlast[3]  = 1'b0;
    expect_now("tie_fall", 32'(port_rst_n_out[3]), 32'd0);
    expect_now("tie_err", 32'(drain_timeout_err), 32'h1);
    release_port(3, "tie");

    // Abort: global reset while port 3 drains, then a short request glitch
    tx_tvalid[3] = 1'b1;
    tick();
    tx_tvalid[3] = 1'b0;
    port_rst_req_n[3] = 1'b0;
    wait_sig(0, 3, 1'b1, cyc);
    expect_now("ab_drain", 32'(port_quiesced[3]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    expect_now("ab_rstn", 32'(port_rst_n_out), 32'h0);
    expect_now("ab_quiesced", 32'(port_quiesced), 32'hF);
    expect_now("ab_err", 32'(drain_timeout_err), 32'h0);
    @(negedge clk);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    port_rst_req_n[3] = 1'b1;
    tick(3);
    port_rst_req_n[3] = 1'b0;
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (port_rst_n_out[3] !== 1'b0) cyc++;
    end
    expect_now("ab_no_rel", 32'(cyc), 32'd0);
    expect_now("ab_others", 32'(port_rst_n_out), 32'h7);
    release_port(3, "ab");

    // Repeated reset requests on port 1
    n_req = 0;
    for (int r = 0; r < 3; r++) begin
      port_rst_req_n[1] = 1'b0;
      wait_sig(2, 1, 1'b1, cyc);
      if (port_quiesced[1] === 1'b1) n_req++;
      release_port(1, $sformatf("st%0d", r));
    end
`ifdef PG_RST_SEQ_STATS_EN
    for (int p = 0; p < NP; p++)
      expect_now($sformatf("stats_p%0d", p), 32'(rst_event_cnt[p*16 +: 16]),
                 (p == 1) ? 32'(n_req) : 32'd0);
`endif
    expect_now("stats_reqs", 32'(n_req), 32'd3);

    check("sb_left", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
